instr_mem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory from a byte stream before the core runs. It sits between a byte source (UART receiver or debug port) and the write port of the instruction RAM. It parses a length header, packs little-endian bytes into 32-bit words, and issues one word-aligned write per word. It also checks a trailing XOR checksum and holds `busy` high so the core can be kept in reset while loading.

---
 rtl/instr_mem_loader.sv | 112 +++++++++++
 tb/tb_instr_mem_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot loader turning a length-prefixed byte stream into instruction memory word writes
// Ports: clk/rst_n clock and async active-low reset; start begins a load (IDLE/DONE only);
//        byte_valid/byte_data/byte_ready byte stream handshake; wr_en/wr_addr/wr_data memory write port;
//        busy high while loading; done level when finished; err_len header count > rows; err_csum checksum mismatch.
module instr_mem_loader #(
    parameter int rows      = 64,
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 wr_en,
    output logic [word_size-1:0] wr_addr,
    output logic [word_size-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err_len,
    output logic                 err_csum
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE} state_t;
    state_t               state;
    logic [7:0]           count_lo;
    logic [15:0]          words_left;
    logic [1:0]           byte_idx;
    logic [word_size-3:0] word_idx;
    logic [7:0]           acc;
    logic [31:0]          asm_word;
    logic [31:0]          asm_next;
    logic [15:0]          n_hdr;
    logic                 xfer;
    assign xfer  = byte_valid && byte_ready;
    assign n_hdr = {byte_data, count_lo};
    // Word with the incoming byte dropped into its lane; on lane 3 this is the complete word.
    always_comb begin
        asm_next = asm_word;
        asm_next[{byte_idx, 3'b000} +: 8] = byte_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count_lo   <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            word_idx   <= '0;
            acc        <= '0;
            asm_word   <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            err_csum   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= HDR0;
                    byte_ready <= 1'b1;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    err_len    <= 1'b0;
                    err_csum   <= 1'b0;
                    word_idx   <= '0;
                    byte_idx   <= '0;
                    acc        <= '0;
                end
                HDR0: if (xfer) begin
                    count_lo <= byte_data;
                    state    <= HDR1;
                end
                HDR1: if (xfer) begin
                    words_left <= n_hdr;
                    if (n_hdr > 16'(rows)) begin
                        err_len    <= 1'b1;
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        state <= (n_hdr == 16'd0) ? CSUM : DATA;
                    end
                end
                DATA: if (xfer) begin
                    asm_word <= asm_next;
                    acc      <= acc ^ byte_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= {word_idx, 2'b00};
                        wr_data    <= asm_next;
                        word_idx   <= word_idx + 1'b1;
                        words_left <= words_left - 16'd1;
                        if (words_left == 16'd1) state <= CSUM;
                    end
                end
                CSUM: if (xfer) begin
                    err_csum   <= (byte_data != acc);
                    state      <= DONE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic        byte_valid = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_ready, wr_en, busy, done, err_len, err_csum;
    logic [31:0] wr_addr, wr_data;
    int          errs = 0;
    int          checks = 0;
    logic [63:0] sb[$];
    logic [31:0] words[64];

    instr_mem_loader #(.rows(64), .word_size(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err_len(err_len), .err_csum(err_csum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && wr_en) begin
        if (sb.size() == 0) chk("spurious_wr", 32'd1, 32'd0);
        else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("wr_addr", wr_addr, e[63:32]);
            chk("wr_data", wr_data, e[31:0]);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        byte_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_valid = 1;
        byte_data  = b;
        while (!byte_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (!byte_ready) begin
            chk("byte_ready_timeout", 32'd0, 32'd1);
            byte_valid = 0;
            return;
        end
        @(posedge clk); #1;
        byte_valid = 0;
    endtask

    task automatic do_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("start_ready", byte_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_flags", {err_len, err_csum}, 0);
    endtask

    task automatic load(input int n, input int gmax, input bit hs, input logic [7:0] cd);
        logic [7:0] cs = 0;
        logic [7:0] b;
        send_byte(n[7:0], $urandom_range(0, gmax));
        send_byte(n[15:8], $urandom_range(0, gmax));
        start = hs;
        for (int w = 0; w < n; w++)
            for (int l = 0; l < 4; l++) begin
                b = words[w][8*l +: 8];
                cs ^= b;
                if (l == 3) sb.push_back({32'(w) << 2, words[w]});
                send_byte(b, $urandom_range(0, gmax));
                chk("wr_en_lane", wr_en, (l == 3) ? 1 : 0);
            end
        start = 0;
        send_byte(cs ^ cd, $urandom_range(0, gmax));
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_ready", byte_ready, 0);
        chk("end_err_csum", err_csum, (cd != 0) ? 1 : 0);
        chk("end_err_len", err_len, 0);
        chk("end_sb_empty", sb.size(), 0);
    endtask

    initial begin
        #3;
        chk("rst_outs", {byte_ready, wr_en, busy, done, err_len, err_csum}, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        // abort a load with reset after six payload bytes
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) sb.push_back({32'h0, words[0]});
            send_byte(words[i/4][8*(i%4) +: 8], 0);
        end
        #2 rst_n = 0;
        #1;
        chk("amid_outs", {byte_ready, wr_en, busy, done, err_len, err_csum}, 0);
        chk("amid_addr", wr_addr, 0);
        chk("amid_data", wr_data, 0);
        chk("amid_sb", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        // two-word load
        do_start();
        load(2, 0, 0, 8'h00);
        // stalled stream
        do_start();
        load(2, 5, 0, 8'h00);
        // bad checksum
        do_start();
        load(2, 0, 0, 8'h01);
        do_start();
        // length overflow, continuing from the restart above
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        chk("ovf_done", done, 1);
        chk("ovf_err_len", err_len, 1);
        chk("ovf_ready", byte_ready, 0);
        chk("ovf_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_hold", {done, err_len}, 2'b11);
        // zero length
        do_start();
        load(0, 0, 0, 8'h00);
        // full length with start held high during payload
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        do_start();
        load(64, 1, 1, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("final_sb", sb.size(), 0);
        chk("final_done", done, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
